pipe_fetch_unit: RTL and testbench
==================================

Name: pipe_fetch_unit

Overview:
Instruction-fetch stage that feeds the IF/ID pipeline register. It owns the program counter and issues requests to instruction memory over a valid/ready handshake. It presents the fetched instruction and PC+4 to the IF/ID register, and honours the decode-stage write enable (wpcir) as its stall and accept signal. It applies branch, jump and jr redirects with one architectural delay slot.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset.
NOP_INST, 32'h0000_0000, bubble instruction presented when no valid instruction is available (sll $0,$0,0).

Ports:
clock  in  1  system clock, rising edge.
resetn  in  1  asynchronous active-low reset.
wpcir  in  1  1 = IF/ID register accepts this cycle; 0 = stall.
pcsource  in  2  next-PC select from decode: 00 pc+4, 01 branch (bpc), 10 jr (da), 11 jump (jpc).
bpc  in  32  branch target.
da  in  32  jr register target.
jpc  in  32  jump target.
imem_req  out  1  request valid.
imem_addr  out  32  request word address (byte address, bits[1:0]=0).
imem_ready  in  1  memory returns data this cycle; may be combinational from imem_req.
imem_rdata  in  32  instruction data, valid when imem_req && imem_ready.
pc  out  32  address of the instruction currently presented or being fetched.
pc4  out  32  pc + 4, for the IF/ID register.
ins  out  32  instruction for the IF/ID register.
ins_valid  out  1  ins holds a real instruction (not a bubble).

Behaviour:
- Clock domain and reset: one clock, clock; reset resetn is asynchronous, active-low.
- Reset values: state=S_IDLE, pc=RESET_PC, ibuf=0, redirect_pending=0, redirect_target=0.
- Reset outputs: imem_req=0, ins=NOP_INST, ins_valid=0, pc4=RESET_PC+4.
- States:
  - S_IDLE: imem_req=0. Moves unconditionally to S_FETCH on the next edge.
  - S_FETCH: imem_req=1, imem_addr=pc, both held stable until imem_ready.
    - If imem_ready && wpcir: the instruction passes straight through (ins=imem_rdata, ins_valid=1). At the edge, pc<=next_pc and the state stays S_FETCH. Zero-wait memory sustains 1 instruction per cycle.
    - If imem_ready && !wpcir: ibuf<=imem_rdata, go to S_HOLD.
    - If !imem_ready: ins=NOP_INST, ins_valid=0, stay in S_FETCH.
  - S_HOLD: imem_req=0, ins=ibuf, ins_valid=1. When wpcir=1, pc<=next_pc and go to S_FETCH; otherwise hold.
- pc4 is always pc+4, modulo 2^32; it wraps from 32'hFFFF_FFFC to 0.
- Redirect capture (delay slot): in any state, an edge with wpcir=1 and pcsource!=00 means decode resolved a control transfer.
  - The selected target (bpc/da/jpc) is applied to the fetch after the instruction currently in IF, which is the delay slot.
  - If that instruction is consumed at the same edge, next_pc = selected target directly.
  - Otherwise redirect_target<=target and redirect_pending<=1.
- next_pc priority: same-cycle redirect > redirect_pending ? redirect_target > pc+4. redirect_pending clears on consume.
- A second redirect while one is pending overwrites the pending target (last wins); the bench must not rely on this outside error cases.
- wpcir=0 blocks pc update, consume and redirect capture. pcsource is ignored while wpcir=0.
- Targets are used as given; bits[1:0] are forced to 0 on imem_addr.
- Reset mid-request: imem_req drops asynchronously and the in-flight transaction is abandoned. Instruction memory must tolerate a dropped request.
- No outstanding requests beyond one; imem_rdata is ignored when imem_req=0.

Decomposition:
- Shared package (mips_pipe_pkg):
  - pcsource encodings PCS_SEQ=2'b00, PCS_BR=2'b01, PCS_JR=2'b10, PCS_J=2'b11.
  - NOP_INST constant.
  - Fetch state enum S_IDLE/S_FETCH/S_HOLD.
- One natural sub-module: pipe_npc_mux. Combinational 4:1 target select plus the pending/same-cycle priority, reused by the decode-stage branch logic.

Test Plan:
- Reset then zero-wait memory (imem_ready tied 1), wpcir=1 → imem_req rises 1 cycle after reset release; pc sequence 0,4,8,C on consecutive cycles; pc4 = pc+4; ins_valid=1 every cycle.
- Memory with 2 wait cycles → ins=NOP_INST, ins_valid=0 for 2 cycles; imem_addr stable; instruction delivered on the 3rd cycle; pc advances by 4.
- Data returns while wpcir=0 for 3 cycles → S_HOLD; imem_req=0; ins stable = returned word; pc unchanged. On wpcir=1, the next fetch is at pc+4.
- At pc=0x10 with the instruction at 0x10 still waiting on memory, assert pcsource=01, bpc=0x40, wpcir=1 → 0x10 is still delivered (delay slot); the next imem_addr is 0x40, not 0x14.
- Same-cycle consume plus jump: pcsource=11, jpc=0x100 → next imem_addr=0x100. jr with da=0x2000 → next imem_addr=0x2000.
- resetn pulsed low during S_FETCH wait → imem_req=0 immediately; pc=RESET_PC; ins=NOP_INST; fetch resumes from RESET_PC after S_IDLE.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline front end: next-PC select codes,
// the bubble instruction and the fetch FSM states.
package mips_pipe_pkg;

   localparam logic [1:0] PCS_SEQ = 2'b00;
   localparam logic [1:0] PCS_BR  = 2'b01;
   localparam logic [1:0] PCS_JR  = 2'b10;
   localparam logic [1:0] PCS_J   = 2'b11;

   // sll $0,$0,0
   localparam logic [31:0] NOP_INST = 32'h0000_0000;

   typedef enum logic [1:0] {
      S_IDLE  = 2'b00,
      S_FETCH = 2'b01,
      S_HOLD  = 2'b10
   } fetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/pipe_npc_mux.sv
// Next-PC selection: 4:1 control-transfer target select plus the
// same-cycle redirect > pending redirect > sequential priority.
module pipe_npc_mux
   import mips_pipe_pkg::*;
(
   input  logic [1:0]  pcsource,
   input  logic        redirect_en,
   input  logic [31:0] pc4,
   input  logic [31:0] bpc,
   input  logic [31:0] da,
   input  logic [31:0] jpc,
   input  logic        redirect_pending,
   input  logic [31:0] redirect_target,
   output logic        redirect_now,
   output logic [31:0] target,
   output logic [31:0] next_pc
);

   always_comb begin
      target = pc4;
      unique case (pcsource)
         PCS_SEQ: target = pc4;
         PCS_BR:  target = bpc;
         PCS_JR:  target = da;
         PCS_J:   target = jpc;
         default: target = pc4;
      endcase
   end

   assign redirect_now = redirect_en && (pcsource != PCS_SEQ);

   always_comb begin
      next_pc = pc4;
      if (redirect_now)
         next_pc = target;
      else if (redirect_pending)
         next_pc = redirect_target;
   end

endmodule

// File: rtl/pipe_fetch_unit.sv
// Instruction-fetch stage: owns the PC, fetches over a req/ready handshake and
// feeds the IF/ID register, with one-delay-slot branch/jump/jr redirects.
module pipe_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = mips_pipe_pkg::NOP_INST
) (
   input  logic        clock,
   input  logic        resetn,
   input  logic        wpcir,
   input  logic [1:0]  pcsource,
   input  logic [31:0] bpc,
   input  logic [31:0] da,
   input  logic [31:0] jpc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc,
   output logic [31:0] pc4,
   output logic [31:0] ins,
   output logic        ins_valid,
   output logic [1:0]  fetch_state
);

   import mips_pipe_pkg::*;

   // Handshake: imem_req and imem_addr are held stable from the cycle the
   // request is raised until imem_ready is seen high at a rising edge; a
   // transfer happens exactly on cycles with imem_req && imem_ready, and
   // imem_rdata is only looked at on those cycles.

   fetch_state_e state, state_nxt;
   logic [31:0]  ibuf;
   logic         redirect_pending;
   logic [31:0]  redirect_target;
   logic         mem_done;
   logic         consume;
   logic         redirect_now;
   logic [31:0]  sel_target;
   logic [31:0]  next_pc;

   assign pc4         = pc + 32'd4;
   assign imem_addr   = word_align(pc);
   assign fetch_state = state;

   assign mem_done = (state == S_FETCH) && imem_ready;
   // The instruction in IF leaves for ID only when decode accepts it.
   assign consume  = wpcir && (mem_done || (state == S_HOLD));

   pipe_npc_mux u_npc_mux (
      .pcsource         (pcsource),
      .redirect_en      (wpcir),
      .pc4              (pc4),
      .bpc              (bpc),
      .da               (da),
      .jpc              (jpc),
      .redirect_pending (redirect_pending),
      .redirect_target  (redirect_target),
      .redirect_now     (redirect_now),
      .target           (sel_target),
      .next_pc          (next_pc)
   );

   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  state_nxt = S_FETCH;
         S_FETCH: if (imem_ready && !wpcir) state_nxt = S_HOLD;
         S_HOLD:  if (wpcir) state_nxt = S_FETCH;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      imem_req  = 1'b0;
      ins       = NOP_INST;
      ins_valid = 1'b0;
      unique case (state)
         S_IDLE: ;
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ready) begin
               ins       = imem_rdata;
               ins_valid = 1'b1;
            end
         end
         S_HOLD: begin
            ins       = ibuf;
            ins_valid = 1'b1;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn)
         state <= S_IDLE;
      else
         state <= state_nxt;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         pc               <= RESET_PC;
         ibuf             <= 32'h0;
         redirect_pending <= 1'b0;
         redirect_target  <= 32'h0;
      end else begin
         if (consume) begin
            pc               <= next_pc;
            redirect_pending <= 1'b0;
         end else if (redirect_now) begin
            // Delay slot still in IF: remember where to go after it.
            redirect_target  <= sel_target;
            redirect_pending <= 1'b1;
         end
         if (mem_done && !wpcir)
            ibuf <= imem_rdata;
      end
   end

endmodule

// File: tb/tb_pipe_fetch_unit.sv
// Bench for pipe_fetch_unit: directed test-plan sequences plus randomized
// stall/wait/redirect traffic checked against an instruction-stream model.
module tb_pipe_fetch_unit;

   import mips_pipe_pkg::*;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clock = 1'b0;
   logic        resetn;
   logic        wpcir;
   logic [1:0]  pcsource;
   logic [31:0] bpc, da, jpc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_ready;
   logic [31:0] imem_rdata;
   logic [31:0] pc, pc4, ins;
   logic        ins_valid;
   logic [1:0]  fetch_state;

   int errors = 0;
   int checks = 0;

   // model of the fetch stream
   bit          m_active, m_have, m_pend;
   logic [31:0] m_pc, m_word, m_tgt;
   logic [31:0] exp_q[$];

   // samples from the latest cycle
   logic [31:0] s_pc, s_pc4, s_addr, s_ins;
   logic        s_req, s_val;

   // ---------------- clock / reset ----------------
   always #5 clock = ~clock;

   pipe_fetch_unit #(.RESET_PC(RST_PC), .NOP_INST(NOP_INST)) dut (
      .clock       (clock),
      .resetn      (resetn),
      .wpcir       (wpcir),
      .pcsource    (pcsource),
      .bpc         (bpc),
      .da          (da),
      .jpc         (jpc),
      .imem_req    (imem_req),
      .imem_addr   (imem_addr),
      .imem_ready  (imem_ready),
      .imem_rdata  (imem_rdata),
      .pc          (pc),
      .pc4         (pc4),
      .ins         (ins),
      .ins_valid   (ins_valid),
      .fetch_state (fetch_state)
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a * 32'h9E37_79B1 + 32'd1;
   endfunction

   assign imem_rdata = mem_word(imem_addr);

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_active = 0; m_have = 0; m_pend = 0;
      m_pc = RST_PC; m_word = 32'h0; m_tgt = 32'h0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      resetn = 1'b0; wpcir = 1'b0; pcsource = PCS_SEQ;
      bpc = 32'h0; da = 32'h0; jpc = 32'h0; imem_ready = 1'b0;
      repeat (2) @(posedge clock);
      @(negedge clock);
      check("rst_req", {31'b0, imem_req}, 32'h0);
      check("rst_ins", ins, NOP_INST);
      check("rst_valid", {31'b0, ins_valid}, 32'h0);
      check("rst_pc4", pc4, RST_PC + 32'd4);
      check("rst_state", {30'b0, fetch_state}, {30'b0, S_IDLE});
      @(posedge clock); #1;
      resetn = 1'b1;
      model_reset();
   endtask

   // ---------------- driver: one clock cycle ----------------
   task automatic cycle(input bit wp, input logic [1:0] pcs, input logic [31:0] b,
                        input logic [31:0] d, input logic [31:0] j, input bit rdy);
      logic        e_req, e_val, redirect;
      logic [31:0] e_ins, e_addr, tgt;
      logic [1:0]  e_state;
      wpcir = wp; pcsource = pcs; bpc = b; da = d; jpc = j; imem_ready = rdy;
      @(negedge clock);
      e_req   = m_active && !m_have;
      e_addr  = {m_pc[31:2], 2'b00};
      e_val   = m_have || (e_req && rdy);
      e_ins   = m_have ? m_word : (e_val ? mem_word(e_addr) : NOP_INST);
      e_state = !m_active ? S_IDLE : (m_have ? S_HOLD : S_FETCH);
      check("imem_req", {31'b0, imem_req}, {31'b0, e_req});
      if (e_req) check("imem_addr", imem_addr, e_addr);
      check("pc", pc, m_pc);
      check("pc4", pc4, m_pc + 32'd4);
      check("ins", ins, e_ins);
      check("ins_valid", {31'b0, ins_valid}, {31'b0, e_val});
      check("state", {30'b0, fetch_state}, {30'b0, e_state});
      s_pc = pc; s_pc4 = pc4; s_addr = imem_addr; s_ins = ins;
      s_req = imem_req; s_val = ins_valid;

      // scoreboard: instructions handed to decode, in order
      if (e_val && wp) exp_q.push_back(e_ins);
      if (ins_valid && wpcir) begin
         if (exp_q.size() == 0) check("sb_underflow", 32'h1, 32'h0);
         else check("sb_ins", ins, exp_q.pop_front());
      end

      // model advance for this edge
      redirect = wp && (pcs != PCS_SEQ);
      tgt = (pcs == PCS_BR) ? b : ((pcs == PCS_JR) ? d : j);
      if (e_val && wp) begin
         m_pc   = redirect ? tgt : (m_pend ? m_tgt : m_pc + 32'd4);
         m_pend = 0;
         m_have = 0;
      end else begin
         if (redirect) begin
            m_pend = 1;
            m_tgt  = tgt;
         end
         if (e_val && !wp && !m_have) begin
            m_have = 1;
            m_word = e_ins;
         end
      end
      m_active = 1;
      @(posedge clock); #1;
   endtask

   // ---------------- stimulus ----------------
   initial begin
      bit          wp, rdy;
      logic [1:0]  pcs;
      logic [31:0] rb, rd, rj;

      do_reset();

      // zero-wait memory, decode always accepting
      cycle(1, PCS_SEQ, 0, 0, 0, 1);
      check("idle_req", {31'b0, s_req}, 32'h0);
      for (int i = 0; i < 4; i++) begin
         cycle(1, PCS_SEQ, 0, 0, 0, 1);
         check("seq_pc", s_pc, 32'(i * 4));
         check("seq_valid", {31'b0, s_val}, 32'h1);
      end

      // two wait states at 0x10, with a branch resolved while waiting
      cycle(1, PCS_BR, 32'h40, 0, 0, 0);
      check("wait_valid", {31'b0, s_val}, 32'h0);
      check("wait_addr", s_addr, 32'h10);
      cycle(1, PCS_SEQ, 0, 0, 0, 0);
      check("wait_ins", s_ins, NOP_INST);
      check("wait_addr2", s_addr, 32'h10);
      cycle(1, PCS_SEQ, 0, 0, 0, 1);
      check("slot_ins", s_ins, mem_word(32'h10));

      // branch target fetched after the delay slot; same-cycle jump
      cycle(1, PCS_J, 0, 0, 32'h100, 1);
      check("br_addr", s_addr, 32'h40);

      // data returns under a 3-cycle stall
      for (int i = 0; i < 3; i++) begin
         cycle(0, PCS_J, 0, 0, 32'h700, 1);
         check("hold_pc", s_pc, 32'h100);
      end
      check("hold_req", {31'b0, s_req}, 32'h0);
      check("hold_ins", s_ins, mem_word(32'h100));
      cycle(1, PCS_SEQ, 0, 0, 0, 1);
      cycle(1, PCS_JR, 0, 32'h2000, 0, 1);
      check("after_hold", s_addr, 32'h104);
      cycle(1, PCS_J, 0, 0, 32'hFFFF_FFFC, 1);
      check("jr_addr", s_addr, 32'h2000);
      cycle(1, PCS_SEQ, 0, 0, 0, 1);
      check("wrap_pc4", s_pc4, 32'h0);
      cycle(1, PCS_SEQ, 0, 0, 0, 1);
      check("wrap_pc", s_pc, 32'h0);

      // randomized traffic
      for (int i = 0; i < 800; i++) begin
         wp  = ($urandom_range(0, 4) != 0);
         rdy = ($urandom_range(0, 3) != 0);
         pcs = PCS_SEQ;
         if (!m_pend && $urandom_range(0, 5) == 0) pcs = 2'($urandom_range(1, 3));
         rb = $urandom(); rd = $urandom(); rj = $urandom();
         if ($urandom_range(0, 7) != 0) begin
            rb = rb & 32'hFFFF_FFFC; rd = rd & 32'hFFFF_FFFC; rj = rj & 32'hFFFF_FFFC;
         end
         cycle(wp, pcs, rb, rd, rj, rdy);
      end

      // reset while a fetch is waiting on memory
      cycle(1, PCS_SEQ, 0, 0, 0, 0);
      cycle(1, PCS_SEQ, 0, 0, 0, 0);
      check("pre_rst_req", {31'b0, imem_req}, 32'h1);
      #2 resetn = 1'b0;
      #1;
      check("arst_req", {31'b0, imem_req}, 32'h0);
      check("arst_pc", pc, RST_PC);
      check("arst_ins", ins, NOP_INST);
      check("arst_valid", {31'b0, ins_valid}, 32'h0);
      @(posedge clock); #1;
      resetn = 1'b1;
      model_reset();
      cycle(1, PCS_SEQ, 0, 0, 0, 1);
      check("rearm_req", {31'b0, s_req}, 32'h0);
      cycle(1, PCS_SEQ, 0, 0, 0, 1);
      check("resume_addr", s_addr, RST_PC);

      for (int i = 0; i < 300; i++) begin
         wp  = ($urandom_range(0, 3) != 0);
         rdy = ($urandom_range(0, 2) != 0);
         pcs = PCS_SEQ;
         if (!m_pend && $urandom_range(0, 4) == 0) pcs = 2'($urandom_range(1, 3));
         cycle(wp, pcs, $urandom() & 32'hFFFF_FFFC, $urandom() & 32'hFFFF_FFFC,
               $urandom() & 32'hFFFF_FFFC, rdy);
      end

      check("sb_drained", exp_q.size(), 32'h0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   // hard time limit so the run always ends
   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "time limit");
   end

endmodule
